// File: rtl/modred_pkg.sv
// rtl/modred_pkg.sv - modulus, fold-count, stage-width and chain-offset helpers for modred_pm_pipe
package modred_pkg;

    localparam int MODRED_MAXW = 1024;
    typedef logic [MODRED_MAXW-1:0] modred_wide_t;

    function automatic bit modred_k_ok(input int n, input int k);
        return (k >= 1) && (k <= n - 2);
    endfunction

    function automatic int modred_h_next(input int h, input int n, input int k);
        int r;
        r = h - (n - k) + 1;
        return (r < 1) ? 1 : r;
    endfunction

    // High-part width entering fold i (i = NFOLD gives the final-stage width of 1)
    function automatic int modred_h(input int i, input int n, input int k);
        int h;
        h = n;
        for (int j = 0; j < i; j++) h = modred_h_next(h, n, k);
        return h;
    endfunction

    function automatic int modred_nfold(input int n, input int k);
        int h;
        int cnt;
        h   = n;
        cnt = 0;
        if (!modred_k_ok(n, k)) return 1;
        for (int j = 0; j < n && h > 1; j++) begin
            h   = modred_h_next(h, n, k);
            cnt = cnt + 1;
        end
        return cnt;
    endfunction

    function automatic modred_wide_t modred_p(input int n, input int k);
        modred_wide_t one_n;
        modred_wide_t one_k;
        one_n    = '0;
        one_n[n] = 1'b1;
        one_k    = '0;
        one_k[k] = 1'b1;
        return one_n - one_k + modred_wide_t'(1);
    endfunction

    // Bit offset of inter-stage segment i inside the flattened data chain
    function automatic int modred_off(input int i, input int n, input int k);
        int off;
        off = 0;
        for (int j = 0; j < i; j++) off = off + n + modred_h(j, n, k);
        return off;
    endfunction

    function automatic bit modred_bound_ok(input int n, input int k);
        modred_wide_t one_n;
        modred_wide_t mid;
        modred_wide_t p2;
        int           hl;
        hl       = modred_h(modred_nfold(n, k) - 1, n, k);
        one_n    = '0;
        one_n[n] = 1'b1;
        mid      = ~({MODRED_MAXW{1'b1}} << hl);
        mid      = mid << k;
        p2       = modred_p(n, k) << 1;
        return (one_n + mid) < p2;
    endfunction

endpackage

// File: rtl/modred_if.sv
// rtl/modred_if.sv - operand/result handshake bundle for modred_pm_pipe; tag lines under MODRED_TAG_EN
interface modred_if #(
    parameter int N     = 256,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   in_data;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
`ifdef MODRED_TAG_EN
    logic [TAG_W-1:0] in_tag;
    logic [TAG_W-1:0] out_tag;
`endif

    if (TAG_W < 1) begin : g_bad_tag_w
        $error("modred_if: TAG_W must be at least 1");
    end

    modport master (
`ifdef MODRED_TAG_EN
        output in_tag,
        input  out_tag,
`endif
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );

    modport slave (
`ifdef MODRED_TAG_EN
        input  in_tag,
        output out_tag,
`endif
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data
    );
endinterface

// File: rtl/modred_fold_stage.sv
// rtl/modred_fold_stage.sv - one fold h*2^N + l -> h*2^K + l - h with an elastic register slot
module modred_fold_stage
    import modred_pkg::*;
#(
    parameter int N     = 256,
    parameter int K     = 168,
`ifdef MODRED_TAG_EN
    parameter int TAG_W = 8,
`endif
    parameter int HIN   = 256,
    localparam int HOUT = modred_h_next(HIN, N, K),
    localparam int W    = N + HOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [N+HIN-1:0] up_data,
`ifdef MODRED_TAG_EN
    input  logic [TAG_W-1:0] up_tag,
    output logic [TAG_W-1:0] dn_tag,
`endif
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [W-1:0]     dn_data
);
    logic [HIN-1:0] h;
    logic [N-1:0]   l;
    logic [W-1:0]   csa_a;
    logic [W-1:0]   csa_b;
    logic [W-1:0]   csa_c;
    logic [W-1:0]   csa_s;
    logic [W-1:0]   csa_cy;
    logic           valid_q;
    logic [W-1:0]   data_q;

    assign h = up_data[N+HIN-1:N];
    assign l = up_data[N-1:0];

    // ~h over W bits is -h-1; the +1 rides in bit 0 of h<<K, which is always zero since K >= 1
    assign csa_a  = (W'(h) << K) | W'(1);
    assign csa_b  = W'(l);
    assign csa_c  = ~W'(h);
    assign csa_s  = csa_a ^ csa_b ^ csa_c;
    assign csa_cy = ((csa_a & csa_b) | (csa_a & csa_c) | (csa_b & csa_c)) << 1;

    assign up_ready = !valid_q || dn_ready;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (up_ready) valid_q <= up_valid;
            if (up_ready && up_valid) data_q <= csa_s + csa_cy;
        end
    end

`ifdef MODRED_TAG_EN
    logic [TAG_W-1:0] tag_q;

    assign dn_tag = tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else if (up_ready && up_valid) begin
            tag_q <= up_tag;
        end
    end
`endif
endmodule

// File: rtl/modred_pm_pipe.sv
// rtl/modred_pm_pipe.sv - pipelined a mod (2^N - 2^K + 1); MODRED_TAG_EN adds a sideband tag
module modred_pm_pipe
    import modred_pkg::*;
#(
    parameter int N     = 256,
    parameter int K     = 168,
    parameter int TAG_W = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    modred_if.slave bus
);
    localparam int           NFOLD   = modred_nfold(N, K);
    localparam int           CHAIN_W = modred_off(NFOLD + 1, N, K);
    localparam modred_wide_t P_WIDE  = modred_p(N, K);
    localparam logic [N:0]   P       = P_WIDE[N:0];

    if (!modred_k_ok(N, K)) begin : g_bad_k
        $error("modred_pm_pipe: K must lie in [1, N-2]");
    end else if (!modred_bound_ok(N, K)) begin : g_bad_bound
        $error("modred_pm_pipe: last-fold bound reaches 2p, one final subtract is not enough");
    end
    if (TAG_W < 1) begin : g_bad_tag_w
        $error("modred_pm_pipe: TAG_W must be at least 1");
    end

    // Segment i of the chain is the value entering fold i, N + H(i) bits wide
    logic [CHAIN_W-1:0] chain;
    logic [NFOLD:0]     st_valid;
    logic [NFOLD:0]     st_ready;
    logic [N:0]         fin_v;
    logic [N:0]         fin_s;
    logic               out_valid_q;
    logic [N-1:0]       out_data_q;

    assign chain[2*N-1:0] = bus.in_data;
    assign st_valid[0]    = bus.in_valid;
    assign bus.in_ready   = st_ready[0];

`ifdef MODRED_TAG_EN
    logic [TAG_W-1:0] st_tag [0:NFOLD];
    logic [TAG_W-1:0] out_tag_q;

    assign st_tag[0]   = bus.in_tag;
    assign bus.out_tag = out_tag_q;
`endif

    for (genvar i = 0; i < NFOLD; i++) begin : g_fold
        localparam int HIN    = modred_h(i, N, K);
        localparam int HOUT   = modred_h(i + 1, N, K);
        localparam int LO_IN  = modred_off(i, N, K);
        localparam int LO_OUT = modred_off(i + 1, N, K);

        modred_fold_stage #(
            .N     (N),
            .K     (K),
`ifdef MODRED_TAG_EN
            .TAG_W (TAG_W),
`endif
            .HIN   (HIN)
        ) u_fold (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (st_valid[i]),
            .up_ready (st_ready[i]),
            .up_data  (chain[LO_IN +: N + HIN]),
`ifdef MODRED_TAG_EN
            .up_tag   (st_tag[i]),
            .dn_tag   (st_tag[i+1]),
`endif
            .dn_valid (st_valid[i+1]),
            .dn_ready (st_ready[i+1]),
            .dn_data  (chain[LO_OUT +: N + HOUT])
        );
    end

    // After the last fold v < 2p, so one conditional subtract finishes the reduction
    assign fin_v           = chain[CHAIN_W-1 -: N+1];
    assign fin_s           = fin_v - P;
    assign st_ready[NFOLD] = !out_valid_q || bus.out_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (st_ready[NFOLD]) out_valid_q <= st_valid[NFOLD];
            if (st_ready[NFOLD] && st_valid[NFOLD]) begin
                out_data_q <= fin_s[N] ? fin_v[N-1:0] : fin_s[N-1:0];
            end
        end
    end

`ifdef MODRED_TAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_tag_q <= '0;
        end else if (st_ready[NFOLD] && st_valid[NFOLD]) begin
            out_tag_q <= st_tag[NFOLD];
        end
    end
`endif
endmodule

// File: tb/tb_modred_pm_pipe.sv
// tb/tb_modred_pm_pipe.sv - self-checking bench for modred_pm_pipe at N=256/K=168 and N=64/K=32
`timescale 1ns/1ps
module tb_modred_pm_pipe;
    localparam int N1 = 256;
    localparam int K1 = 168;
    localparam int N2 = 64;
    localparam int K2 = 32;
    localparam int LAT1 = 4;
    localparam logic [511:0] P1 = (512'd1 << 256) - (512'd1 << 168) + 512'd1;
    localparam logic [127:0] P2 = (128'd1 << 64) - (128'd1 << 32) + 128'd1;

    typedef struct {
        logic [255:0] data;
        logic [7:0]   tag;
        int           acc_cyc;
        bit           lat;
        bit           seen;
    } exp1_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst2_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   lat_mode = 1'b0;
    bit   done2 = 1'b0;
    bit   prev_rst_n = 1'b0;
    exp1_t        q1[$];
    logic [63:0]  q2[$];
    logic [511:0] dvec [6];
    logic [511:0] pm1_sq;
    logic [127:0] p2m1_sq;

    modred_if #(.N(N1), .TAG_W(8)) bus1 ();
    modred_if #(.N(N2), .TAG_W(8)) bus2 ();

    modred_pm_pipe #(.N(N1), .K(K1), .TAG_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    modred_pm_pipe #(.N(N2), .K(K2), .TAG_W(8)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] model1(input logic [511:0] a);
        logic [511:0] r;
        r = a % P1;
        return r[255:0];
    endfunction

    function automatic logic [63:0] model2(input logic [127:0] a);
        logic [127:0] r;
        r = a % P2;
        return r[63:0];
    endfunction

    function automatic void check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard for the N=256 instance: in-flight count, order, data, tag and latency
    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
            check("rst_out_valid", 512'(bus1.out_valid), 512'd0);
            check("rst_out_data", 512'(bus1.out_data), 512'd0);
        end else begin
            if (!prev_rst_n) check("in_ready_after_rst", 512'(bus1.in_ready), 512'd1);
            check("in_ready_rule", 512'(bus1.in_ready), 512'(bus1.out_ready || (q1.size() < LAT1)));
            if (bus1.out_valid) begin
                if (q1.size() == 0) begin
                    check("spurious_result", 512'(bus1.out_valid), 512'd0);
                end else begin
                    check("out_data", 512'(bus1.out_data), 512'(q1[0].data));
`ifdef MODRED_TAG_EN
                    check("out_tag", 512'(bus1.out_tag), 512'(q1[0].tag));
`endif
                    if (q1[0].lat && !q1[0].seen) check("latency", 512'(cyc - q1[0].acc_cyc), 512'(LAT1));
                    q1[0].seen = 1'b1;
                    if (bus1.out_ready) void'(q1.pop_front());
                end
            end
            if (bus1.in_valid && bus1.in_ready) begin
                exp1_t e;
                e.data    = model1(bus1.in_data);
`ifdef MODRED_TAG_EN
                e.tag     = bus1.in_tag;
`else
                e.tag     = 8'd0;
`endif
                e.acc_cyc = cyc;
                e.lat     = lat_mode;
                e.seen    = 1'b0;
                q1.push_back(e);
            end
        end
        prev_rst_n = rst_n;
    end

    always @(negedge clk) begin
        if (rst2_n) begin
            if (bus2.out_valid) begin
                if (q2.size() == 0) begin
                    check("spurious_result2", 512'(bus2.out_valid), 512'd0);
                end else begin
                    check("out_data2", 512'(bus2.out_data), 512'(q2[0]));
                    if (bus2.out_ready) void'(q2.pop_front());
                end
            end
            if (bus2.in_valid && bus2.in_ready) q2.push_back(model2(bus2.in_data));
        end
    end

    task automatic send1(input logic [511:0] a, input logic [7:0] t);
        int b;
        b = 0;
        bus1.in_valid = 1'b1;
        bus1.in_data  = a;
`ifdef MODRED_TAG_EN
        bus1.in_tag   = t;
`else
        if (t == 8'hFF) b = 0;
`endif
        @(negedge clk);
        while (!bus1.in_ready && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("send_accept", 512'(bus1.in_ready), 512'd1);
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
    endtask

    task automatic drain1();
        int b;
        b = 0;
        while ((q1.size() != 0 || bus1.out_valid) && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("drain_empty", 512'(q1.size()), 512'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Random traffic on the N=64 instance with random backpressure
    initial begin
        logic [127:0] a;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.out_ready = 1'b1;
`ifdef MODRED_TAG_EN
        bus2.in_tag    = '0;
`endif
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0:       a = '1;
                1:       a = p2m1_sq;
                2:       a = 128'($urandom_range(0, 1000));
                3:       a = P2 - 128'd1;
                default: a = {$urandom, $urandom, $urandom, $urandom};
            endcase
            bus2.in_valid  = ($urandom_range(0, 3) != 0);
            bus2.in_data   = a;
            bus2.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("dut2_drained", 512'(q2.size()), 512'd0);
        done2 = 1'b1;
    end

    initial begin
        rst_n          = 1'b0;
        rst2_n         = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b1;
`ifdef MODRED_TAG_EN
        bus1.in_tag    = '0;
`endif
        pm1_sq  = (P1 - 512'd1) * (P1 - 512'd1);
        p2m1_sq = (P2 - 128'd1) * (P2 - 128'd1);
        dvec[0] = '0;
        dvec[1] = P1;
        dvec[2] = P1 - 512'd1;
        dvec[3] = 512'd1 << 256;
        dvec[4] = '1;
        dvec[5] = pm1_sq;

        check("pin_zero", 512'(model1(dvec[0])), 512'd0);
        check("pin_p", 512'(model1(dvec[1])), 512'd0);
        check("pin_p_minus_1", 512'(model1(dvec[2])), P1 - 512'd1);
        check("pin_2pow256", 512'(model1(dvec[3])), (512'd1 << 168) - 512'd1);
        check("pin_pm1_sq", 512'(model1(pm1_sq)), 512'd1);
        check("pin64_2pow64", 512'(model2(128'd1 << 64)), (512'd1 << 32) - 512'd1);
        check("pin64_pm1_sq", 512'(model2(p2m1_sq)), 512'd1);

        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rst2_n = 1'b1;

        lat_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send1(dvec[i], 8'(i));
            drain1();
        end
        lat_mode = 1'b0;

        fork
            begin
                for (int i = 0; i < 10; i++) send1(rnd512(), 8'(i));
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                bus1.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bus1.out_ready = 1'b1;
            end
        join
        drain1();

        for (int i = 0; i < 3; i++) send1(rnd512(), 8'(i));
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat_mode = 1'b1;
        send1(dvec[5], 8'h55);
        drain1();
        lat_mode = 1'b0;

`ifdef MODRED_TAG_EN
        fork
            begin
                for (int i = 0; i < 16; i++) send1(rnd512(), 8'(i));
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    bus1.out_ready = $urandom_range(0, 1) != 0;
                end
                bus1.out_ready = 1'b1;
            end
        join
        drain1();
`endif

        for (int b = 0; b < 6000 && !done2; b++) @(posedge clk);
        check("dut2_done", 512'(done2), 512'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
